// File: rtl/fpu_operand_queue.sv
// Issue queue for the FP add/sub core: DEPTH-entry FIFO that classifies IEEE-754 special operands at push time.
// Optional statistics counters are enabled by defining FPU_QUEUE_STATS_EN.
module fpu_operand_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic                     in_addsub,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_a,
    output logic [31:0]              out_b,
    output logic                     out_addsub,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_special,
    output logic [31:0]              out_bypass,
    output logic [$clog2(DEPTH):0]   count
`ifdef FPU_QUEUE_STATS_EN
    ,
    output logic [15:0]              stat_special,
    output logic [15:0]              stat_full
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             addsub;
        logic [TAG_W-1:0] tag;
        logic             special;
        logic [31:0]      bypass;
    } entry_t;

    // The adder only handles normal finite operands, so everything else gets a precomputed result here.
    function automatic entry_t classify(
        input logic [31:0]      a,
        input logic [31:0]      b,
        input logic             addsub,
        input logic [TAG_W-1:0] tag
    );
        entry_t e;
        logic   sa;
        logic   sb_eff;
        logic   a_zero;
        logic   b_zero;
        logic   a_inf;
        logic   b_inf;
        logic   a_nan;
        logic   b_nan;

        sa     = a[31];
        sb_eff = b[31] ^ addsub;
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

        e.a       = a;
        e.b       = b;
        e.addsub  = addsub;
        e.tag     = tag;
        e.special = 1'b1;
        e.bypass  = '0;

        if (a_nan || b_nan) begin
            e.bypass = QNAN;
        end else if (a_inf && b_inf && (sa != sb_eff)) begin
            e.bypass = QNAN;
        end else if (a_inf) begin
            e.bypass = a;
        end else if (b_inf) begin
            e.bypass = {sb_eff, b[30:0]};
        end else if (a_zero && b_zero) begin
            e.bypass = {sa & sb_eff, 31'd0};
        end else if (a_zero) begin
            e.bypass = {sb_eff, b[30:0]};
        end else if (b_zero) begin
            // A is known normal here, so no denormal flush is needed.
            e.bypass = a;
        end else begin
            e.special = 1'b0;
        end
        return e;
    endfunction

    entry_t            mem [DEPTH];
    entry_t            new_entry;
    entry_t            head;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              push;
    logic              pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign new_entry = classify(in_a, in_b, in_addsub, in_tag);

    // NOTE: the storage array has no reset; count gates every read, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Outputs are forced to zero while empty so reset clears them without waiting for an edge.
    assign head        = mem[rd_ptr];
    assign out_a       = out_valid ? head.a       : '0;
    assign out_b       = out_valid ? head.b       : '0;
    assign out_addsub  = out_valid ? head.addsub  : 1'b0;
    assign out_tag     = out_valid ? head.tag     : '0;
    assign out_special = out_valid ? head.special : 1'b0;
    assign out_bypass  = out_valid ? head.bypass  : '0;

`ifdef FPU_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_special <= '0;
            stat_full    <= '0;
        end else if (flush) begin
            stat_special <= '0;
            stat_full    <= '0;
        end else begin
            if (push && new_entry.special && (stat_special != 16'hFFFF)) begin
                stat_special <= stat_special + 16'd1;
            end
            if ((count == FULL) && in_valid && (stat_full != 16'hFFFF)) begin
                stat_full <= stat_full + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_operand_queue.sv
// Scoreboard bench for fpu_operand_queue: a reference queue model tracks accepted pushes, a negedge monitor compares.
`timescale 1ns/1ps
module tb_fpu_operand_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic              in_addsub;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_a;
    logic [31:0]       out_b;
    logic              out_addsub;
    logic [TAG_W-1:0]  out_tag;
    logic              out_special;
    logic [31:0]       out_bypass;
    logic [$clog2(DEPTH):0] count;
`ifdef FPU_QUEUE_STATS_EN
    logic [15:0]       stat_special;
    logic [15:0]       stat_full;
`endif

    fpu_operand_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_addsub   (in_addsub),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_addsub  (out_addsub),
        .out_tag     (out_tag),
        .out_special (out_special),
        .out_bypass  (out_bypass),
        .count       (count)
`ifdef FPU_QUEUE_STATS_EN
        ,
        .stat_special(stat_special),
        .stat_full   (stat_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             addsub;
        logic [TAG_W-1:0] tag;
        logic             special;
        logic [31:0]      bypass;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        drv_special;
    logic [31:0] drv_bypass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepts a push only when not full before this edge's pop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            bit do_push;
            bit do_pop;
            exp_t e;
            do_push = in_valid && (exp_q.size() != DEPTH);
            do_pop  = out_ready && (exp_q.size() != 0);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                e.a = in_a; e.b = in_b; e.addsub = in_addsub; e.tag = in_tag;
                e.special = drv_special; e.bypass = drv_bypass;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compares occupancy, handshakes and the head entry away from the active edge.
    always @(negedge clk) begin
        check("count", 32'(count), 32'(exp_q.size()));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
        if (exp_q.size() != 0) begin
            check("out_a", out_a, exp_q[0].a);
            check("out_b", out_b, exp_q[0].b);
            check("out_addsub", 32'(out_addsub), 32'(exp_q[0].addsub));
            check("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
            check("out_special", 32'(out_special), 32'(exp_q[0].special));
            check("out_bypass", out_bypass, exp_q[0].bypass);
        end
    end

    task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic as, input logic [TAG_W-1:0] tag,
                         input logic es, input logic [31:0] eb,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid    = iv;
        in_a        = a;
        in_b        = b;
        in_addsub   = as;
        in_tag      = tag;
        drv_special = es;
        drv_bypass  = eb;
        out_ready   = ordy;
        flush       = fl;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'd0, 32'd0, 1'b0, '0, 1'b0, 32'd0, ordy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_addsub = 1'b0; in_tag = '0; out_ready = 1'b0;
        drv_special = 1'b0; drv_bypass = '0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_a", out_a, 32'd0);
        check("rst_out_bypass", out_bypass, 32'd0);
        rst_n = 1'b1;

        // Single normal request, then consume it.
        drive(1'b1, 32'h3F800000, 32'h3F000000, 1'b0, 4'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill past capacity, try a push while full and popping, then drain in order.
        for (int t = 0; t < 5; t++)
            drive(1'b1, 32'h40000000 + t, 32'h3F800000, t[0], t[TAG_W-1:0], 1'b0, 32'd0, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b1, 32'h41000000, 32'h3F800000, 1'b0, 4'hF, 1'b0, 32'd0, 1'b1, 1'b0);
        repeat (5) idle(1'b1);
        idle(1'b0);

        // Special-case classification vectors with hand-derived bypass results.
        drive(1'b1, 32'h7F800000, 32'h7F800000, 1'b1, 4'h2, 1'b1, 32'h7FC00000, 1'b1, 1'b0);
        drive(1'b1, 32'h7F800000, 32'hFF800000, 1'b1, 4'h3, 1'b1, 32'h7F800000, 1'b1, 1'b0);
        drive(1'b1, 32'h00000000, 32'hBFC00000, 1'b1, 4'h4, 1'b1, 32'h3FC00000, 1'b1, 1'b0);
        drive(1'b1, 32'h80000000, 32'h00000000, 1'b1, 4'h5, 1'b1, 32'h80000000, 1'b1, 1'b0);
        drive(1'b1, 32'h7F800001, 32'h3F800000, 1'b0, 4'h6, 1'b1, 32'h7FC00000, 1'b1, 1'b0);
        drive(1'b1, 32'h00000000, 32'hFFFFFFFF, 1'b0, 4'h7, 1'b1, 32'h7FC00000, 1'b1, 1'b0);
        drive(1'b1, 32'h3F800000, 32'h7F800000, 1'b1, 4'h8, 1'b1, 32'hFF800000, 1'b1, 1'b0);
        drive(1'b1, 32'hC0490FDB, 32'h80000000, 1'b0, 4'h9, 1'b1, 32'hC0490FDB, 1'b1, 1'b0);
        drive(1'b1, 32'h00400000, 32'h3F800000, 1'b0, 4'hA, 1'b1, 32'h3F800000, 1'b1, 1'b0);
        drive(1'b1, 32'h80000001, 32'h00000000, 1'b0, 4'hB, 1'b1, 32'h00000000, 1'b1, 1'b0);
        drive(1'b1, 32'h3FC00000, 32'hC0000000, 1'b1, 4'hC, 1'b0, 32'd0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Simultaneous push and pop at occupancy 2.
        drive(1'b1, 32'h40400000, 32'h40800000, 1'b0, 4'd5, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h40A00000, 32'h40C00000, 1'b1, 4'd6, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h40E00000, 32'h41000000, 1'b0, 4'd7, 1'b0, 32'd0, 1'b1, 1'b0);
        idle(1'b0);
        repeat (2) idle(1'b1);
        idle(1'b0);

        // Flush at occupancy 3 with a concurrent push that must be dropped.
        for (int t = 0; t < 3; t++)
            drive(1'b1, 32'h3F800000, 32'h3F800000 + t, 1'b0, 4'(t + 8), 1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h7F800000, 32'h3F800000, 1'b0, 4'hE, 1'b1, 32'h7F800000, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // Refill, then assert reset between clock edges.
        for (int t = 0; t < 3; t++)
            drive(1'b1, 32'h42000000 + t, 32'h3F000000, 1'b1, 4'(t + 1), 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_a", out_a, 32'd0);
        check("async_rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Queue works normally after reset.
        drive(1'b1, 32'h3F800000, 32'h7F800000, 1'b0, 4'd3, 1'b1, 32'h7F800000, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
